// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU-side types used by the memory arbiter.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake state reported by the memory (FREE/BUSY/ACCESS/ERROR)
//   arbstate_t  : arbiter FSM state (IDLE/IGNT/DGNT)
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arbstate_t;

    // Bits needed to hold a saturating count in 0..limit (limit >= 1).
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if -- groups every memory_arbiter signal except clock/reset.
//   instruction side : iREN, iaddr (in)   / iwait, iload (out)
//   data side        : dREN, dWEN, daddr, dstore (in) / dwait, dload (out)
//   RAM side         : ramload, ramstate (in) / ramREN, ramWEN, ramaddr, ramstore (out)
//   ARB_STATS_EN     : adds istall_cnt, dstall_cnt, err_cnt (out, 32 b each)
// Modports: arb (arbiter view), tb (driver/observer view).
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

`ifdef ARB_STATS_EN
    logic [31:0] istall_cnt;
    logic [31:0] dstall_cnt;
    logic [31:0] err_cnt;
`endif

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
`ifdef ARB_STATS_EN
        output istall_cnt, dstall_cnt, err_cnt,
`endif
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
`ifdef ARB_STATS_EN
        input  istall_cnt, dstall_cnt, err_cnt,
`endif
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter -- arbitrates one RAM port between instruction fetch and
// data access. Data wins by default; an instruction request that has watched
// STARVE_LIMIT consecutive data completions wins the next arbitration.
//   CLK   : clock, all state on rising edge
//   nRST  : asynchronous active-low reset
//   bus   : memory_arbiter_if.arb (requester, response and RAM signals)
// Parameter STARVE_LIMIT (>= 1): max consecutive data grants while iREN waits.
// Optional macro ARB_STATS_EN: enables istall_cnt/dstall_cnt/err_cnt counters.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic             CLK,
    input logic             nRST,
    memory_arbiter_if.arb   bus
);
    import cpu_types_pkg::*;

    localparam int            CW    = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arbstate_t     state, next_state;
    logic [CW-1:0] starve_cnt;
    logic          dreq, done_i, done_d, starved;

    assign dreq    = bus.dREN | bus.dWEN;
    assign starved = bus.iREN && (starve_cnt == LIMIT);
    // Completion needs the owner still requesting; a dropped request while
    // the RAM reports ACCESS is an abort, not a completion.
    assign done_i  = (state == IGNT) && bus.iREN && (bus.ramstate == ACCESS);
    assign done_d  = (state == DGNT) && dreq     && (bus.ramstate == ACCESS);

    // State register: the only source of the grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Next state. ERROR/BUSY/FREE keep the grant so the access is re-presented.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (starved)       next_state = IGNT;
                else if (dreq)     next_state = DGNT;
                else if (bus.iREN) next_state = IGNT;
                else               next_state = IDLE;
            end
            IGNT:    if (!bus.iREN || done_i) next_state = IDLE;
            DGNT:    if (!dreq || done_d)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: RAM strobes decode from state only; waits/loads add completion.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IGNT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
            end
            DGNT: begin
                bus.ramREN   = bus.dREN;
                bus.ramWEN   = bus.dWEN & ~bus.dREN;  // read wins when both set
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
            end
            default: ;
        endcase
        bus.iwait = bus.iREN & ~done_i;
        bus.dwait = dreq & ~done_d;
        bus.iload = done_i ? bus.ramload : '0;
        bus.dload = done_d ? bus.ramload : '0;
    end

    // Consecutive data completions seen by a waiting instruction request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_cnt <= '0;
        else if (!bus.iREN || done_i)
            starve_cnt <= '0;
        else if (done_d && (starve_cnt != LIMIT))
            starve_cnt <= starve_cnt + CW'(1);
    end

`ifdef ARB_STATS_EN
    logic [31:0] istall_q, dstall_q, err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            istall_q <= '0;
            dstall_q <= '0;
            err_q    <= '0;
        end else begin
            if (bus.iwait) istall_q <= istall_q + 32'd1;
            if (bus.dwait) dstall_q <= dstall_q + 32'd1;
            if ((state != IDLE) && (bus.ramstate == ERROR)) err_q <= err_q + 32'd1;
        end
    end

    assign bus.istall_cnt = istall_q;
    assign bus.dstall_cnt = dstall_q;
    assign bus.err_cnt    = err_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter -- directed scenarios plus a randomized run checked
// against a transaction-level owner/starvation model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int SL = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_LIMIT(SL)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = FREE; bus.ramload = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = ACCESS;
        bus.iaddr = 32'h11; bus.daddr = 32'h22; bus.dstore = 32'h33; bus.ramload = 32'h44;
        #3;
        n_cmp++; if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== 4'b0011) begin
            n_bad++; $display("FAIL reset_strobes_waits: got %b want %b", {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, 4'b0011); end
        n_cmp++; if ({bus.ramaddr, bus.ramstore} !== 64'h0) begin
            n_bad++; $display("FAIL reset_ram_bus: got %h want 0", {bus.ramaddr, bus.ramstore}); end
        n_cmp++; if ({bus.iload, bus.dload} !== 64'h0) begin
            n_bad++; $display("FAIL reset_loads: got %h want 0", {bus.iload, bus.dload}); end
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        #1;
        n_cmp++; if ({bus.iwait, bus.dwait} !== 2'b00) begin
            n_bad++; $display("FAIL reset_waits_idle: got %b want 00", {bus.iwait, bus.dwait}); end
`ifdef ARB_STATS_EN
        n_cmp++; if ({bus.istall_cnt, bus.dstall_cnt, bus.err_cnt} !== 96'h0) begin
            n_bad++; $display("FAIL reset_stats: got %h want 0", {bus.istall_cnt, bus.dstall_cnt, bus.err_cnt}); end
`endif
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_ifetch();
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        #3;
        n_cmp++; if ({bus.ramREN, bus.iwait} !== 2'b01) begin
            n_bad++; $display("FAIL ifetch_c0: got %b want 01", {bus.ramREN, bus.iwait}); end
        tick();
        bus.ramstate = BUSY;
        #3;
        n_cmp++; if ({bus.ramREN, bus.iwait, bus.ramaddr, bus.iload} !== {2'b11, 32'h40, 32'h0}) begin
            n_bad++; $display("FAIL ifetch_c1: got %h want %h", {bus.ramREN, bus.iwait, bus.ramaddr, bus.iload}, {2'b11, 32'h40, 32'h0}); end
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        #3;
        n_cmp++; if ({bus.iwait, bus.iload} !== {1'b0, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL ifetch_c2: got %h want %h", {bus.iwait, bus.iload}, {1'b0, 32'hDEADBEEF}); end
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        #3;
        n_cmp++; if ({bus.ramREN, bus.ramaddr, bus.iload} !== 65'h0) begin
            n_bad++; $display("FAIL ifetch_c3_idle: got %h want 0", {bus.ramREN, bus.ramaddr, bus.iload}); end
    endtask

    task automatic test_contention();
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.dREN = 1'b1; bus.daddr = 32'h100;
        tick();
        #3;
        n_cmp++; if ({bus.ramREN, bus.ramaddr, bus.dwait} !== {1'b1, 32'h100, 1'b1}) begin
            n_bad++; $display("FAIL contend_dgnt: got %h want %h", {bus.ramREN, bus.ramaddr, bus.dwait}, {1'b1, 32'h100, 1'b1}); end
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        #1;
        n_cmp++; if ({bus.dwait, bus.iwait, bus.dload, bus.iload} !== {2'b01, 32'h55, 32'h0}) begin
            n_bad++; $display("FAIL contend_dload: got %h want %h", {bus.dwait, bus.iwait, bus.dload, bus.iload}, {2'b01, 32'h55, 32'h0}); end
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        #3;
        n_cmp++; if (bus.ramREN !== 1'b0) begin
            n_bad++; $display("FAIL contend_idle: got %b want 0", bus.ramREN); end
        tick();
        #3;
        n_cmp++; if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h200}) begin
            n_bad++; $display("FAIL contend_ignt: got %h want %h", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h200}); end
        bus.ramstate = ACCESS; bus.ramload = 32'h77;
        #1;
        n_cmp++; if ({bus.iwait, bus.iload} !== {1'b0, 32'h77}) begin
            n_bad++; $display("FAIL contend_iload: got %h want %h", {bus.iwait, bus.iload}, {1'b0, 32'h77}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        int nd = 0, ni = 0, first_i = -1;
        do_reset();
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = ACCESS;
        for (int c = 0; c < 2 * (SL + 1); c++) begin
            bus.ramload = 32'(c);
            #3;
            if (!bus.dwait) nd++;
            if (!bus.iwait) begin ni++; if (first_i < 0) first_i = nd; end
            tick();
        end
        n_cmp++; if (nd !== SL || ni !== 1) begin
            n_bad++; $display("FAIL starve_counts: got d=%0d i=%0d want d=%0d i=1", nd, ni, SL); end
        n_cmp++; if (first_i !== SL) begin
            n_bad++; $display("FAIL starve_order: got instr after %0d data want %0d", first_i, SL); end
        idle_inputs();
    endtask

    task automatic test_write_error();
        int nwen = 0, ndone = 0;
        ramstate_t seq [3] = '{ERROR, ERROR, ACCESS};
        do_reset();
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
        tick();
        for (int c = 0; c < 3; c++) begin
            bus.ramstate = seq[c];
            #3;
            if (bus.ramWEN && !bus.ramREN && bus.ramaddr == 32'h80 && bus.ramstore == 32'h1234) nwen++;
            if (!bus.dwait) ndone++;
            n_cmp++; if (bus.dwait !== (seq[c] != ACCESS)) begin
                n_bad++; $display("FAIL werr_dwait_c%0d: got %b want %b", c, bus.dwait, seq[c] != ACCESS); end
            tick();
        end
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        #3;
        n_cmp++; if (nwen !== 3 || ndone !== 1 || bus.ramWEN !== 1'b0) begin
            n_bad++; $display("FAIL werr_summary: got wen=%0d done=%0d wen_after=%b want 3 1 0", nwen, ndone, bus.ramWEN); end
`ifdef ARB_STATS_EN
        n_cmp++; if (bus.err_cnt !== 32'd2) begin
            n_bad++; $display("FAIL werr_err_cnt: got %0d want 2", bus.err_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
        tick();
        #3;
        n_cmp++; if (bus.ramREN !== 1'b1) begin
            n_bad++; $display("FAIL rmid_granted: got %b want 1", bus.ramREN); end
        nRST = 1'b0;
        #1;
        n_cmp++; if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dwait} !== {2'b00, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL rmid_abort: got %h want %h", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dwait}, {2'b00, 32'h0, 1'b1}); end
        bus.ramstate = ACCESS;
        tick();
        nRST = 1'b1;
        #3;
        n_cmp++; if ({bus.ramREN, bus.dwait, bus.dload} !== {2'b01, 32'h0}) begin
            n_bad++; $display("FAIL rmid_no_done: got %h want %h", {bus.ramREN, bus.dwait, bus.dload}, {2'b01, 32'h0}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_rw_both();
        do_reset();
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.ramstate = BUSY;
        tick();
        #3;
        n_cmp++; if ({bus.ramREN, bus.ramWEN} !== 2'b10) begin
            n_bad++; $display("FAIL rw_both: got %b want 10", {bus.ramREN, bus.ramWEN}); end
        idle_inputs();
    endtask

    // Randomized run. Model: who owns the RAM (0 none, 1 instr, 2 data) and
    // how many data completions a waiting fetch has watched.
    task automatic test_random();
        int owner = 0, starve = 0;
        int unsigned m_is = 0, m_ds = 0, m_er = 0;
        logic drq, ifin, dfin, e_iw, e_dw, e_ren, e_wen;
        word_t e_addr, e_store;
        bit rst_now;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_now      = ($urandom_range(0, 199) == 0);
            nRST         = !rst_now;
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 2) == 0);
            bus.dWEN     = ($urandom_range(0, 2) == 0);
            bus.iaddr    = $urandom; bus.daddr = $urandom;
            bus.dstore   = $urandom; bus.ramload = $urandom;
            bus.ramstate = ramstate_t'($urandom_range(0, 3));
            if (rst_now) begin owner = 0; starve = 0; m_is = 0; m_ds = 0; m_er = 0; end
            #3;
            drq     = bus.dREN | bus.dWEN;
            ifin    = (owner == 1) && bus.iREN && (bus.ramstate == ACCESS);
            dfin    = (owner == 2) && drq && (bus.ramstate == ACCESS);
            e_iw    = bus.iREN && !ifin;
            e_dw    = drq && !dfin;
            e_ren   = (owner == 1) || ((owner == 2) && bus.dREN);
            e_wen   = (owner == 2) && bus.dWEN && !bus.dREN;
            e_addr  = (owner == 1) ? bus.iaddr : (owner == 2) ? bus.daddr : 32'h0;
            e_store = (owner == 2) ? bus.dstore : 32'h0;
            n_cmp++; if ({bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait} !== {e_ren, e_wen, e_iw, e_dw}) begin
                n_bad++; $display("FAIL rnd_ctl c%0d: got %b want %b", c, {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait}, {e_ren, e_wen, e_iw, e_dw}); end
            n_cmp++; if (bus.ramaddr !== e_addr) begin
                n_bad++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.ramaddr, e_addr); end
            n_cmp++; if (bus.ramstore !== e_store) begin
                n_bad++; $display("FAIL rnd_store c%0d: got %h want %h", c, bus.ramstore, e_store); end
            n_cmp++; if (bus.iload !== (ifin ? bus.ramload : 32'h0)) begin
                n_bad++; $display("FAIL rnd_iload c%0d: got %h want %h", c, bus.iload, ifin ? bus.ramload : 32'h0); end
            n_cmp++; if (bus.dload !== (dfin ? bus.ramload : 32'h0)) begin
                n_bad++; $display("FAIL rnd_dload c%0d: got %h want %h", c, bus.dload, dfin ? bus.ramload : 32'h0); end
            if (!rst_now) begin
                m_is += e_iw; m_ds += e_dw;
                if (owner != 0 && bus.ramstate == ERROR) m_er++;
                case (owner)
                    0: owner = (bus.iREN && starve == SL) ? 1 : drq ? 2 : bus.iREN ? 1 : 0;
                    1: owner = (!bus.iREN || ifin) ? 0 : 1;
                    default: owner = (!drq || dfin) ? 0 : 2;
                endcase
                if (!bus.iREN || ifin) starve = 0;
                else if (dfin && starve < SL) starve++;
            end
            tick();
        end
        nRST = 1'b1;
        idle_inputs();
`ifdef ARB_STATS_EN
        #3;
        n_cmp++; if ({bus.istall_cnt, bus.dstall_cnt, bus.err_cnt} !== {m_is, m_ds, m_er}) begin
            n_bad++; $display("FAIL rnd_stats: got %0d/%0d/%0d want %0d/%0d/%0d", bus.istall_cnt, bus.dstall_cnt, bus.err_cnt, m_is, m_ds, m_er); end
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ifetch();
        test_contention();
        test_starvation();
        test_write_error();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
